mult_seq_ctrl: RTL

Sequencing controller plus shift-add engine for the board-level multiplier. It takes debounced single-cycle button pulses from the Pushbutton block and operand switches. It captures operand A and then operand B, runs a WIDTH-cycle shift-add multiply, and holds the product for display until the operator advances. It sits between the Pushbutton instances and the display/LED driver.

---
 rtl/mult_seq_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mult_seq_ctrl.sv
// Operand-entry sequencer with a serial shift-add multiplier for the board multiplier.
// Latency: the product is valid and done=1 exactly WIDTH edges after the edge that accepts operand B.
// Backpressure: none. Button pulses are consumed when legal, btn_next in S_RUN is dropped, and btn_clr always wins.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   btn_next  one-cycle pulse: capture A, capture B and start, or leave S_DONE
//   btn_clr   one-cycle pulse: abort to operand-A entry and zero the product
//   sw        operand switches, sampled only when btn_next is accepted
//   product   registered 2*WIDTH-bit result, held until the next completion or clear
//   busy      high while the multiply runs
//   done      high while the result is being shown
//   phase     state code for the LEDs: 0 A-entry, 1 B-entry, 2 run, 3 done
module mult_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_next,
   input  logic               btn_clr,
   input  logic [WIDTH-1:0]   sw,
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic               done,
   output logic [1:0]         phase
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic [CW-1:0]      count_q, count_d;
   logic               busy_q, done_q;
   logic [2*WIDTH-1:0] sum;

   // The accumulator value after this cycle's iteration. On the last
   // iteration it becomes the product directly, which saves one cycle.
   assign sum = acc_q + (b_q[0] ? mcand_q : '0);

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      product_d = product_q;
      count_d   = count_q;

      if (btn_clr) begin
         // Clear takes priority, so a btn_next in the same cycle captures nothing.
         state_d   = S_A;
         product_d = '0;
         count_d   = '0;
      end else begin
         unique case (state_q)
            S_A: begin
               if (btn_next) begin
                  a_d     = sw;
                  state_d = S_B;
               end
            end
            S_B: begin
               if (btn_next) begin
                  mcand_d = {{WIDTH{1'b0}}, a_q};
                  b_d     = sw;
                  acc_d   = '0;
                  count_d = '0;
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               // Fixed WIDTH iterations with no early exit, so latency does not depend on the operands.
               acc_d   = sum;
               mcand_d = mcand_q << 1;
               b_d     = b_q >> 1;
               count_d = count_q + 1'b1;
               if (count_q == LAST) begin
                  product_d = sum;
                  state_d   = S_DONE;
               end
            end
            S_DONE: begin
               // Product is held so the display keeps the last result during new entry.
               if (btn_next) state_d = S_A;
            end
            default: state_d = S_A;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_A;
         a_q       <= '0;
         b_q       <= '0;
         mcand_q   <= '0;
         acc_q     <= '0;
         product_q <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         count_q   <= count_d;
         // Status flags are registered from the next state, so they are
         // cycle-aligned with state_q and cannot both be high.
         busy_q    <= (state_d == S_RUN);
         done_q    <= (state_d == S_DONE);
      end
   end

   assign product = product_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign phase   = state_q;

endmodule
